// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO.
// Frame format and baud divisor are latched at each frame start.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [BAUD_W-1:0]            baud_goal,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
    output logic                         TX,
    output logic                         tx_busy,
    output logic                         tx_done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BAUD_W-1:0]    baud_lat_q, baud_lat_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 two_q, two_d;
    logic                 done_q, done_d;
    logic                 tick, start_frame;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = tx_valid && !full;
    assign head       = mem_q[rd_ptr_q];
    assign tx_ready   = !full;
    assign fifo_count = count_q;
    assign tick       = (baud_cnt_q == baud_lat_q);
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = done_q;

    // FIFO storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Transmitter state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            baud_lat_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            baud_lat_q <= baud_lat_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_q      <= two_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; a frame start pops the FIFO and latches config.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        baud_lat_d  = baud_lat_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        two_d       = two_q;
        done_d      = done_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        if (state_q != S_IDLE) begin
            baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!empty) start_frame = 1'b1;
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (two_q && bit_cnt_q == '0) begin
                        bit_cnt_d = 1;
                    end else if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_frame) begin
            pop        = 1'b1;
            state_d    = S_START;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = head;
            par_bit_d  = (^head) ^ (parity_mode == 2'b10);
            par_en_d   = parity_mode[0] ^ parity_mode[1];
            baud_lat_d = baud_goal;
            two_d      = two_stop;
            done_d     = 1'b0;
        end
    end

    // Line level decoded from the current state.
    always_comb begin
        TX = 1'b1;
        unique case (state_q)
            S_START:  TX = 1'b0;
            S_DATA:   TX = shift_q[0];
            S_PARITY: TX = par_bit_q;
            default:  TX = 1'b1;
        endcase
    end

endmodule
